// File: rtl/tdc_pkg.sv
// tdc_pkg: shared constants, helpers and timestamp word layout for the TDC hit stamper.
//   FINE_W        fine (phase quadrant) field width
//   ts_width()    total word width for a given coarse width: {marker, coarse, fine}
//   marker_idx()  bit position of the marker flag for a given coarse width
//   ts_word_t     word layout at the default coarse width
package tdc_pkg;

   localparam int unsigned FINE_W       = 2;
   localparam int unsigned COARSE_W_DEF = 16;

   function automatic int unsigned ts_width(input int unsigned coarse_w);
      return coarse_w + FINE_W + 1;
   endfunction

   function automatic int unsigned marker_idx(input int unsigned coarse_w);
      return coarse_w + FINE_W;
   endfunction

   localparam int unsigned MARKER_IDX = marker_idx(COARSE_W_DEF);

   typedef struct packed {
      logic                    marker;
      logic [COARSE_W_DEF-1:0] coarse;
      logic [FINE_W-1:0]       fine;
   } ts_word_t;

endpackage

// File: rtl/tdc_sync_fifo.sv
// tdc_sync_fifo: first-word-fall-through synchronous FIFO.
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_push/i_wdata  write request and data; refused when full unless a pop frees a slot
//   i_pop           read request; ignored when empty
//   o_rdata         head word while non-empty, otherwise the last word popped (0 after reset)
//   o_full/o_empty  occupancy flags
//   o_drop          a push was refused this cycle
// Pointers carry one extra wrap bit to tell full from empty.
module tdc_sync_fifo #(
   parameter int unsigned WIDTH = 19,
   parameter int unsigned DEPTH = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty,
   output logic             o_drop
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]      r_wptr;
   logic [AW:0]      r_rptr;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_last;
   logic             w_full;
   logic             w_empty;
   logic             w_do_push;
   logic             w_do_pop;

   assign w_empty   = (r_wptr == r_rptr);
   assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_do_pop  = i_pop & ~w_empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign w_do_push = i_push & (~w_full | w_do_pop);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_last <= '0;
      end else begin
         if (w_do_push) begin
            r_wptr <= r_wptr + (AW+1)'(1);
         end
         if (w_do_pop) begin
            r_rptr <= r_rptr + (AW+1)'(1);
            r_last <= r_mem[r_rptr[AW-1:0]];
         end
      end
   end

   // Storage needs no reset: the pointers alone decide what is visible.
   always_ff @(posedge i_clk) begin
      if (w_do_push) begin
         r_mem[r_wptr[AW-1:0]] <= i_wdata;
      end
   end

   assign o_rdata = w_empty ? r_last : r_mem[r_rptr[AW-1:0]];
   assign o_full  = w_full;
   assign o_empty = w_empty;
   assign o_drop  = i_push & ~w_do_push;

endmodule

// File: rtl/tdc_hit_stamper.sv
// tdc_hit_stamper: timestamps rising edges of the ISERDES decoder hit flag.
//   clk100     system clock (rising edge)
//   rst_n      asynchronous active-low reset
//   hit_in     decoder hit level, asynchronous
//   phase_in   decoder quadrant code, valid once hit_in has risen
//   ts_data    {marker, coarse, fine} head word
//   ts_valid   head word available
//   ts_ready   consumer accept
//   fifo_full  FIFO holds DEPTH words
//   lost_cnt   saturating count of words dropped on a full FIFO
// Optional feature macro TDC_ROLLOVER_MARK_EN: push a marker word {1, all-ones, 00}
// whenever the coarse counter wraps to zero.
module tdc_hit_stamper
   import tdc_pkg::*;
#(
   parameter int unsigned COARSE_W = 16,
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned OVF_W    = 8
) (
   input  logic                          clk100,
   input  logic                          rst_n,
   input  logic                          hit_in,
   input  logic [FINE_W-1:0]             phase_in,
   output logic [ts_width(COARSE_W)-1:0] ts_data,
   output logic                          ts_valid,
   input  logic                          ts_ready,
   output logic                          fifo_full,
   output logic [OVF_W-1:0]              lost_cnt
);

   localparam int unsigned TS_W = ts_width(COARSE_W);

   typedef struct packed {
      logic                marker;
      logic [COARSE_W-1:0] coarse;
      logic [FINE_W-1:0]   fine;
   } word_t;

   logic [COARSE_W-1:0] r_coarse;
   logic [COARSE_W-1:0] w_coarse_nxt;
   logic                r_h1;
   logic                r_h2;
   logic [COARSE_W-1:0] r_h1_coarse;
   logic                w_rise;
   logic                r_det;
   logic [COARSE_W-1:0] r_det_coarse;
   logic [FINE_W-1:0]   r_det_fine;
   word_t               w_hit_word;
   logic                w_push;
   logic [TS_W-1:0]     w_wdata;
   logic                w_drop;
   logic                w_empty;
   logic                w_full;
   logic [OVF_W-1:0]    r_lost;

   assign w_coarse_nxt = r_coarse + COARSE_W'(1);

   always_ff @(posedge clk100 or negedge rst_n) begin
      if (!rst_n) begin
         r_coarse <= '0;
      end else begin
         r_coarse <= w_coarse_nxt;
      end
   end

   // h1 captures the coarse value of the edge it samples on, so the stamp is the
   // edge where the hit was first seen high.
   always_ff @(posedge clk100 or negedge rst_n) begin
      if (!rst_n) begin
         r_h1        <= 1'b0;
         r_h2        <= 1'b0;
         r_h1_coarse <= '0;
      end else begin
         r_h1        <= hit_in;
         r_h2        <= r_h1;
         r_h1_coarse <= w_coarse_nxt;
      end
   end

   assign w_rise = r_h1 & ~r_h2;

   // Phase is taken one edge after h1 rises, giving the decoder time to settle.
   always_ff @(posedge clk100 or negedge rst_n) begin
      if (!rst_n) begin
         r_det        <= 1'b0;
         r_det_coarse <= '0;
         r_det_fine   <= '0;
      end else begin
         r_det <= w_rise;
         if (w_rise) begin
            r_det_coarse <= r_h1_coarse;
            r_det_fine   <= phase_in;
         end
      end
   end

   always_comb begin
      w_hit_word        = '0;
      w_hit_word.coarse = r_det_coarse;
      w_hit_word.fine   = r_det_fine;
   end

`ifdef TDC_ROLLOVER_MARK_EN
   logic  r_pend;
   logic  w_wrap;
   word_t w_mark_word;

   assign w_wrap = &r_coarse;

   always_comb begin
      w_mark_word        = '0;
      w_mark_word.marker = 1'b1;
      w_mark_word.coarse = '1;
   end

   // Pending marker waits while a hit owns the push slot; a wrap while already
   // pending collapses into the same marker.
   always_ff @(posedge clk100 or negedge rst_n) begin
      if (!rst_n) begin
         r_pend <= 1'b0;
      end else begin
         r_pend <= w_wrap | (r_pend & r_det);
      end
   end

   assign w_push  = r_det | r_pend;
   assign w_wdata = r_det ? w_hit_word : w_mark_word;
`else
   assign w_push  = r_det;
   assign w_wdata = w_hit_word;
`endif

   tdc_sync_fifo #(
      .WIDTH (TS_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk   (clk100),
      .i_rst_n (rst_n),
      .i_push  (w_push),
      .i_wdata (w_wdata),
      .i_pop   (ts_ready),
      .o_rdata (ts_data),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_drop  (w_drop)
   );

   always_ff @(posedge clk100 or negedge rst_n) begin
      if (!rst_n) begin
         r_lost <= '0;
      end else if (w_drop && (r_lost != '1)) begin
         r_lost <= r_lost + OVF_W'(1);
      end
   end

   assign ts_valid  = ~w_empty;
   assign fifo_full = w_full;
   assign lost_cnt  = r_lost;

endmodule

// File: tb/tb_tdc_hit_stamper.sv
// tb_tdc_hit_stamper: self-checking bench for tdc_hit_stamper (COARSE_W=4, DEPTH=16).
// A behavioural model fills a scoreboard queue with the words the FIFO should hold;
// every cycle the DUT head, flags and loss count are compared against it. A vector
// table drives hit level patterns, and hand sequences cover timing, wrap, full and reset.
module tb_tdc_hit_stamper;
   import tdc_pkg::*;

   localparam int unsigned CW    = 4;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned OVF_W = 8;
   localparam int unsigned TW    = CW + FINE_W + 1;

   logic             clk100   = 1'b0;
   logic             rst_n    = 1'b0;
   logic             hit_in   = 1'b0;
   logic [1:0]       phase_in = 2'd0;
   logic             ts_ready = 1'b0;
   logic [TW-1:0]    ts_data;
   logic             ts_valid;
   logic             fifo_full;
   logic [OVF_W-1:0] lost_cnt;

   int n_checks = 0;
   int n_pass   = 0;
   int hit_pops = 0;

   always #5 clk100 = ~clk100;

   tdc_hit_stamper #(
      .COARSE_W (CW),
      .DEPTH    (DEPTH),
      .OVF_W    (OVF_W)
   ) dut (
      .clk100    (clk100),
      .rst_n     (rst_n),
      .hit_in    (hit_in),
      .phase_in  (phase_in),
      .ts_data   (ts_data),
      .ts_valid  (ts_valid),
      .ts_ready  (ts_ready),
      .fifo_full (fifo_full),
      .lost_cnt  (lost_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
   endtask

   task automatic tick();
      @(negedge clk100);
   endtask

   // ---------------- reference model / scoreboard ----------------
   logic [TW-1:0] exp_q[$];
   int            edge_n;
   logic          m_s1, m_s2, m_det, m_pend;
   logic [TW-1:0] m_det_word;
   int            m_lost;

   task automatic model_reset();
      exp_q.delete();
      edge_n = 0; m_s1 = 0; m_s2 = 0; m_det = 0; m_pend = 0; m_det_word = '0; m_lost = 0;
   endtask

   task automatic model_step();
      logic          pop, push, full_before;
      logic [TW-1:0] w;
      logic [CW-1:0] cf;
      edge_n++;
      pop         = ts_ready && (exp_q.size() != 0);
      full_before = (exp_q.size() == DEPTH);
      push        = 1'b0;
      w           = '0;
      if (m_det) begin
         push = 1'b1;
         w    = m_det_word;
      end
`ifdef TDC_ROLLOVER_MARK_EN
      else if (m_pend) begin
         push   = 1'b1;
         w      = {1'b1, {CW{1'b1}}, 2'b00};
         m_pend = 1'b0;
      end
      if ((edge_n % (1 << CW)) == 0) m_pend = 1'b1;
`endif
      if (pop) void'(exp_q.pop_front());
      if (push) begin
         if (full_before && !pop) begin
            if (m_lost < 255) m_lost++;
         end else begin
            exp_q.push_back(w);
         end
      end
      // Rise seen on the previous sample pair; stamp is the edge of the first high sample.
      cf         = CW'((edge_n - 1) % (1 << CW));
      m_det      = m_s1 && !m_s2;
      m_det_word = {1'b0, cf, phase_in};
      m_s2       = m_s1;
      m_s1       = hit_in;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk100 or negedge rst_n);
         if (!rst_n) model_reset();
         else model_step();
      end
   end

   // Per-cycle comparison against the scoreboard, away from both edges' input changes.
   initial begin
      forever begin
         @(negedge clk100);
         #1;
         if (rst_n) begin
            check("valid", ts_valid, exp_q.size() != 0);
            check("full", fifo_full, exp_q.size() == DEPTH);
            check("lost", lost_cnt, m_lost);
            if (exp_q.size() != 0) check("head", ts_data, exp_q[0]);
            if (ts_valid && ts_ready && !ts_data[TW-1]) hit_pops++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   typedef struct {
      int unsigned high_len;
      int unsigned low_len;
      logic [1:0]  phase;
      int unsigned exp_words;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int base;
      int exp_cum;

      vecs[0] = '{high_len: 1,  low_len: 3, phase: 2'd0, exp_words: 1};
      vecs[1] = '{high_len: 50, low_len: 3, phase: 2'd1, exp_words: 1};
      vecs[2] = '{high_len: 2,  low_len: 0, phase: 2'd3, exp_words: 1};
      vecs[3] = '{high_len: 4,  low_len: 2, phase: 2'd2, exp_words: 0};
      vecs[4] = '{high_len: 1,  low_len: 1, phase: 2'd1, exp_words: 1};
      vecs[5] = '{high_len: 5,  low_len: 1, phase: 2'd0, exp_words: 1};
      vecs[6] = '{high_len: 1,  low_len: 4, phase: 2'd2, exp_words: 1};

      // Reset state
      repeat (3) tick();
      #1;
      check("rst_valid", ts_valid, 1'b0);
      check("rst_data", ts_data, '0);
      check("rst_full", fifo_full, 1'b0);
      check("rst_lost", lost_cnt, '0);
      tick();
      rst_n = 1'b1;

      // Single pulse first high at edge 10, phase 2
      repeat (9) tick();
      hit_in = 1'b1; phase_in = 2'd2;
      tick();
      tick();
      hit_in = 1'b0;
      #1;
      check("t1_valid_e11", ts_valid, 1'b0);
      tick();
      #1;
      check("t1_valid_e12", ts_valid, 1'b1);
      check("t1_word", ts_data, 7'b0_1010_10);
      tick();
      ts_ready = 1'b1;
      repeat (3) tick();

      // Level patterns from the table
      base    = hit_pops;
      exp_cum = 0;
      for (int i = 0; i < 7; i++) begin
         hit_in = 1'b1; phase_in = vecs[i].phase;
         repeat (vecs[i].high_len) tick();
         hit_in = 1'b0;
         repeat (vecs[i].low_len) tick();
         exp_cum += vecs[i].exp_words;
         if (vecs[i].high_len + vecs[i].low_len >= 4) begin
            #2;
            check($sformatf("vec%0d_words", i), hit_pops - base, exp_cum);
         end
      end
      repeat (6) tick();
      check("vec_total", hit_pops - base, exp_cum);

      // Hit detected on the coarse wrap edge
      repeat (3) tick();
      while ((edge_n % 16) != 14) tick();
      ts_ready = 1'b0;
      hit_in = 1'b1; phase_in = 2'd1;
      tick();
      hit_in = 1'b0;
      tick();
      #1;
      check("wrap_valid_det", ts_valid, 1'b0);
      tick();
      #1;
      check("wrap_valid", ts_valid, 1'b1);
      check("wrap_hit", ts_data, 7'b0_1111_01);
      tick();
      #1;
      check("wrap_hit_hold", ts_data, 7'b0_1111_01);
      tick();
      ts_ready = 1'b1;
      tick();
      ts_ready = 1'b0;
      #1;
`ifdef TDC_ROLLOVER_MARK_EN
      check("wrap_mark_valid", ts_valid, 1'b1);
      check("wrap_mark", ts_data, 7'b1_1111_00);
`else
      check("wrap_no_mark", ts_valid, 1'b0);
`endif
      tick();
      ts_ready = 1'b1;
      repeat (4) tick();

      // 20 hits into a stalled FIFO
      ts_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         hit_in = 1'b1; phase_in = 2'(i);
         tick();
         hit_in = 1'b0;
         tick();
      end
      repeat (3) tick();
      #1;
      check("full_flag", fifo_full, 1'b1);
`ifndef TDC_ROLLOVER_MARK_EN
      check("full_lost4", lost_cnt, 8'd4);
`endif

      // Push and pop in the same cycle while full
      tick();
      hit_in = 1'b1; phase_in = 2'd3;
      tick();
      hit_in = 1'b0;
      tick();
      ts_ready = 1'b1;
      tick();
      ts_ready = 1'b0;
      #1;
      check("pp_full", fifo_full, 1'b1);
`ifndef TDC_ROLLOVER_MARK_EN
      check("pp_lost", lost_cnt, 8'd4);
`endif

      // Drain in order
      tick();
      ts_ready = 1'b1;
      repeat (20) tick();
      ts_ready = 1'b0;

      // Queue 5 words, leave a hit in flight, then reset asynchronously
      for (int i = 0; i < 5; i++) begin
         hit_in = 1'b1; phase_in = 2'(i);
         tick();
         hit_in = 1'b0;
         tick();
      end
      repeat (2) tick();
      #1;
      check("pre_rst_valid", ts_valid, 1'b1);
      tick();
      hit_in = 1'b1;
      tick();
      hit_in = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valid", ts_valid, 1'b0);
      check("arst_lost", lost_cnt, '0);
      check("arst_full", fifo_full, 1'b0);
      check("arst_data", ts_data, '0);
      tick();
      tick();
      rst_n    = 1'b1;
      ts_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         #1;
         check($sformatf("post_rst_valid%0d", i), ts_valid, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/tdc_hit_stamper.md
Name: tdc_hit_stamper

Overview:
- Sits directly downstream of the ISERDES phase decoder. Consumes its hit-present flag and 2-bit phase quadrant code.
- Combines them with a free-running coarse counter to form a timestamp word per hit.
- Buffers the words in a small synchronous FIFO with a valid/ready read port toward the readout/packetiser.
- Counts hits lost to a full FIFO.

Parameters:
- COARSE_W, 16, coarse counter width (bits); wraps modulo 2^COARSE_W.
- DEPTH, 16, FIFO depth in words; must be a power of 2, at least 4.
- OVF_W, 8, lost-hit counter width; saturating.

Ports:
- clk100  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- hit_in  input  1  decoder enable (high while any ISERDES bit set); asynchronous to logic, level.
- phase_in  input  2  decoder quadrant code (0..3), stable only after hit_in rises.
- ts_data  output  COARSE_W+3  {marker, coarse[COARSE_W-1:0], fine[1:0]}.
- ts_valid  output  1  head word available.
- ts_ready  input  1  consumer accepts when ts_valid&&ts_ready at clock edge.
- fifo_full  output  1  FIFO holds DEPTH words.
- lost_cnt  output  OVF_W  hits dropped because FIFO full; saturates at all-ones.

Behaviour:
- Reset (rst_n low, async): coarse=0, sync stages=0, FIFO empty.
- Reset outputs: ts_valid=0, ts_data=0, fifo_full=0, lost_cnt=0.
- Reset mid-operation discards all stored words; no partial word is emitted after release.
- Coarse counter:
  - Edge 1 after reset release makes it 1; increments every clock thereafter.
  - Wraps 2^COARSE_W-1 -> 0.
- Input pipeline:
  - hit_in passes through 2 flop stages h1, h2.
  - A hit is detected when h1=1 and h2=0, i.e. a rising edge.
  - Coarse is latched alongside h1.
  - phase_in is registered at the edge after h1 first goes high, to let the decoder settle.
- Word contents:
  - A hit first sampled high at edge k is detected at edge k+1.
  - coarse field = k mod 2^COARSE_W.
  - fine = phase_in sampled at edge k+1.
  - marker = 0.
- Latency: the word is pushed at edge k+2. ts_valid rises after edge k+2 if the FIFO was empty (3 edges from first high sample).
- Level behaviour: one word per rising edge of hit_in only. A hit held high for many cycles yields one word. Re-arm requires at least one low sample.
- FIFO:
  - First-word fall-through; ts_data shows the head while ts_valid=1.
  - Pop on ts_valid&&ts_ready.
  - Simultaneous push and pop when full is allowed: pop frees the slot, push succeeds, no loss.
- Full:
  - Push while full without a same-cycle pop drops the word.
  - lost_cnt increments by 1, saturating.
- Empty: ts_ready while ts_valid=0 has no effect; ts_data holds the last value.

Optional Feature:
- Macro: TDC_ROLLOVER_MARK_EN.
- Defined:
  - When coarse wraps to 0, push a marker word {1, all-ones coarse, 2'b00}.
  - If a hit push occurs the same cycle, the hit goes first and the marker is pushed next cycle via a 1-bit pending flag.
  - A marker dropped due to full also increments lost_cnt.
  - A further wrap while pending does not queue a second marker.
- Undefined: no markers; the marker bit is always 0; the pending flag logic is absent.

Decomposition:
- Package tdc_pkg:
  - FINE_W=2.
  - function ts_width(COARSE_W) = COARSE_W+FINE_W+1.
  - Marker bit index constant.
  - Packed struct for the timestamp word {marker, coarse, fine}.
- Sub-module tdc_sync_fifo:
  - Parameterised width/depth, FWFT, with full/empty and push/pop.
  - Pointers carry one extra wrap bit.
  - Instantiated once.

Test Plan:
- Reset then a single hit_in pulse 1->0 over 2 cycles, first high at edge 10, phase_in=2 -> one word coarse=10, fine=2, marker=0; ts_valid high after edge 12.
- hit_in held high 50 cycles -> exactly one word; a second rise after 3 low cycles -> second word with coarse = its own first-high edge.
- ts_ready=0, 20 rising hits with DEPTH=16 -> fifo_full=1 after the 16th push, lost_cnt=4, and the first 16 words are drained in order once ts_ready=1.
- FIFO full with ts_ready=1 and a hit pushed the same cycle -> no loss, lost_cnt unchanged, count stays 16.
- With COARSE_W=4 and TDC_ROLLOVER_MARK_EN, run past the wrap with a hit detected at the wrap edge -> hit word, then the marker word {1,4'hF,2'b00} the next cycle. Without the macro, only the hit word.
- Assert rst_n low with 5 words queued -> ts_valid=0 and lost_cnt=0 immediately (async); after release, no stale words appear.
